// File: rtl/alarm_time_setter.sv
// alarm_time_setter: button-driven alarm hour/minute editor.
// Edge-detected buttons, 3-state edit FSM, auto-repeat, timeout, cancel.
module alarm_time_setter #(
  parameter int RST_HR       = 6,
  parameter int RST_MIN      = 0,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000,
  parameter int TIMEOUT      = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic [5:0] a_hr,
  output logic [5:0] a_min,
  output logic       editing,
  output logic [1:0] field,
  output logic       upd
);
  localparam int HW = $clog2(REPEAT_DELAY) + 1;
  localparam int RW = $clog2(REPEAT_RATE) + 1;
  localparam int IW = $clog2(TIMEOUT) + 1;

  localparam logic [HW-1:0] H_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] H_SAT  = HW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_RATE - 1);
  localparam logic [IW-1:0] I_LAST = IW'(TIMEOUT - 1);
  localparam logic [5:0]    HR0    = 6'(RST_HR);
  localparam logic [5:0]    MIN0   = 6'(RST_MIN);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    btn_q, p;
  logic [5:0]    hr_d, min_d;
  logic [5:0]    sh_hr_q, sh_min_q;
  logic [5:0]    sh_hr_d, sh_min_d;
  logic          upd_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          edit, one_held, hold_full;
  logic          rep_step, inc_s, dec_s;
  logic          timeout, chg, hold_clr;

  function automatic logic [5:0] wrap_up(
    input logic [5:0] v,
    input logic [5:0] top
  );
    return (v >= top) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dn(
    input logic [5:0] v,
    input logic [5:0] top
  );
    return (v == 6'd0 || v > top) ? top : v - 6'd1;
  endfunction

  // Press pulses and the qualified step/timeout strobes
  always_comb begin
    p         = btn & ~btn_q;
    edit      = (state_q != IDLE);
    one_held  = btn[1] ^ btn[2];
    hold_full = (hold_q == H_SAT);
    rep_step  = edit & one_held & ~|p[2:1] &
                ((hold_q == H_LAST) |
                 (hold_full & (rep_q == R_LAST)));
    inc_s     = edit & ~p[3] & ~p[0] &
                ((p[1] & ~p[2]) | (rep_step & btn[1]));
    dec_s     = edit & ~p[3] & ~p[0] &
                ((p[2] & ~p[1]) | (rep_step & btn[2]));
    timeout   = edit & (idle_q == I_LAST) &
                ~|p & ~rep_step;
  end

  // Edit FSM: cancel beats mode beats stepping
  always_comb begin
    state_d  = state_q;
    hr_d     = a_hr;
    min_d    = a_min;
    sh_hr_d  = sh_hr_q;
    sh_min_d = sh_min_q;
    upd_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (p[0]) begin
          state_d  = SET_HR;
          sh_hr_d  = a_hr;
          sh_min_d = a_min;
        end
      end
      SET_HR, SET_MIN: begin
        if (p[3]) begin
          state_d = IDLE;
          hr_d    = sh_hr_q;
          min_d   = sh_min_q;
        end else if (p[0] && state_q == SET_HR) begin
          state_d = SET_MIN;
        end else if (p[0] || timeout) begin
          state_d = IDLE;
          upd_d   = 1'b1;
        end else begin
          unique case (1'b1)
            inc_s && state_q == SET_HR:
              hr_d = wrap_up(a_hr, 6'd23);
            dec_s && state_q == SET_HR:
              hr_d = wrap_dn(a_hr, 6'd23);
            inc_s && state_q == SET_MIN:
              min_d = wrap_up(a_min, 6'd59);
            dec_s && state_q == SET_MIN:
              min_d = wrap_dn(a_min, 6'd59);
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold, repeat and idle counters; any step counts as activity
  always_comb begin
    chg      = (state_d != state_q);
    hold_clr = ~edit | ~one_held | chg | (|p[2:1]);
    hold_d   = hold_q;
    rep_d    = '0;
    idle_d   = idle_q;
    if (hold_clr) begin
      hold_d = '0;
    end else if (!hold_full) begin
      hold_d = hold_q + HW'(1);
    end
    if (!hold_clr && hold_full && rep_q != R_LAST) begin
      rep_d = rep_q + RW'(1);
    end
    if (!edit || chg || (|p) || rep_step) begin
      idle_d = '0;
    end else if (idle_q != I_LAST) begin
      idle_d = idle_q + IW'(1);
    end
  end

  // State, alarm value, shadow and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      btn_q    <= '0;
      a_hr     <= HR0;
      a_min    <= MIN0;
      sh_hr_q  <= HR0;
      sh_min_q <= MIN0;
      upd      <= 1'b0;
      hold_q   <= '0;
      rep_q    <= '0;
      idle_q   <= '0;
    end else begin
      state_q  <= state_d;
      btn_q    <= btn;
      a_hr     <= hr_d;
      a_min    <= min_d;
      sh_hr_q  <= sh_hr_d;
      sh_min_q <= sh_min_d;
      upd      <= upd_d;
      hold_q   <= hold_d;
      rep_q    <= rep_d;
      idle_q   <= idle_d;
    end
  end

  assign editing = (state_q != IDLE);
  assign field   = state_q;

endmodule

// File: tb/tb_alarm_time_setter.sv
// tb_alarm_time_setter: scoreboard bench for alarm_time_setter.
// Stimulus queues expected output events; a monitor pops them on change.
module tb_alarm_time_setter;
  localparam int MODE = 0;
  localparam int INC  = 1;
  localparam int DEC  = 2;
  localparam int CAN  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = '0;
  logic [5:0] a_hr, a_min;
  logic       editing, upd;
  logic [1:0] field;

  alarm_time_setter #(
    .RST_HR      (6),
    .RST_MIN     (0),
    .REPEAT_DELAY(8),
    .REPEAT_RATE (4),
    .TIMEOUT     (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn),
    .a_hr   (a_hr),
    .a_min  (a_min),
    .editing(editing),
    .field  (field),
    .upd    (upd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      nm;
    int         c;
    logic [5:0] hr;
    logic [5:0] mn;
    logic [1:0] f;
    logic       u;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input string nm, input int c,
                           input int hr, input int mn,
                           input logic [1:0] f, input logic u);
    exp_t e;
    e.nm = nm;
    e.c  = c;
    e.hr = 6'(hr);
    e.mn = 6'(mn);
    e.f  = f;
    e.u  = u;
    q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] v, input int n);
    btn = v;
    repeat (n) tick();
    btn = '0;
    tick();
  endtask

  task automatic step(input string nm, input int b,
                      input int hr, input int mn,
                      input logic [1:0] f, input logic cm);
    expect_at(nm, cyc + 1, hr, mn, f, cm);
    if (cm) expect_at({nm, "_end"}, cyc + 2, hr, mn, 2'b00, 1'b0);
    drive(4'(1 << b), 1);
  endtask

  logic [15:0] mon_cur, mon_last;
  bit          mon_have = 0;
  bit          mon_ok;
  exp_t        mon_e;

  always @(negedge clk) begin
    mon_cur = {a_hr, a_min, field, editing, upd};
    if (!mon_have || mon_cur !== mon_last) begin
      n_chk++;
      if (q.size() == 0) begin
        $display("FAIL unexpected: cyc=%0d hr=%0d min=%0d fld=%b upd=%b",
                 cyc, a_hr, a_min, field, upd);
      end else begin
        mon_e  = q.pop_front();
        mon_ok = (mon_e.c < 0 || mon_e.c == cyc) &&
                 a_hr === mon_e.hr && a_min === mon_e.mn &&
                 field === mon_e.f && upd === mon_e.u &&
                 editing === (mon_e.f != 2'b00);
        if (mon_ok) n_pass++;
        else
          $display("FAIL %s: got cyc=%0d hr=%0d min=%0d fld=%b ed=%b upd=%b, want cyc=%0d hr=%0d min=%0d fld=%b upd=%b",
                   mon_e.nm, cyc, a_hr, a_min, field, editing, upd,
                   mon_e.c, mon_e.hr, mon_e.mn, mon_e.f, mon_e.u);
      end
    end
    mon_last = mon_cur;
    mon_have = 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int e0;
    expect_at("reset", -1, 6, 0, 2'b00, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    step("m1", MODE, 6, 0, 2'b01, 0);
    step("i1", INC, 7, 0, 2'b01, 0);
    step("i2", INC, 8, 0, 2'b01, 0);
    step("i3", INC, 9, 0, 2'b01, 0);
    step("m2", MODE, 9, 0, 2'b10, 0);
    step("min_wrap_dn", DEC, 9, 59, 2'b10, 0);
    step("commit", MODE, 9, 59, 2'b00, 1);
    drive(4'b0010, 1);
    drive(4'b0100, 1);
    drive(4'b1000, 1);

    step("m4", MODE, 9, 59, 2'b01, 0);
    for (int h = 10; h <= 23; h++)
      step("hr_up", INC, h, 59, 2'b01, 0);
    step("hr_wrap_up", INC, 0, 59, 2'b01, 0);
    step("hr_wrap_dn", DEC, 23, 59, 2'b01, 0);
    step("m5", MODE, 23, 59, 2'b10, 0);
    step("cancel1", CAN, 9, 59, 2'b00, 0);

    step("m6", MODE, 9, 59, 2'b01, 0);
    step("i4", INC, 10, 59, 2'b01, 0);
    step("m7", MODE, 10, 59, 2'b10, 0);
    expect_at("rst_mid", cyc, 6, 0, 2'b00, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    step("m8", MODE, 6, 0, 2'b01, 0);
    step("i5", INC, 7, 0, 2'b01, 0);
    step("i6", INC, 8, 0, 2'b01, 0);
    step("m9", MODE, 8, 0, 2'b10, 0);
    for (int m = 1; m <= 5; m++)
      step("min_up", INC, 8, m, 2'b10, 0);
    step("cancel2", CAN, 6, 0, 2'b00, 0);

    step("m10", MODE, 6, 0, 2'b01, 0);
    step("i7", INC, 7, 0, 2'b01, 0);
    expect_at("cancel_wins", cyc + 1, 6, 0, 2'b00, 1'b0);
    drive(4'b1011, 1);

    expect_at("mode_held", cyc + 1, 6, 0, 2'b01, 1'b0);
    drive(4'b0001, 5);
    e0 = cyc + 1;
    step("to_inc", INC, 7, 0, 2'b01, 0);
    expect_at("timeout", e0 + 16, 7, 0, 2'b00, 1'b1);
    expect_at("timeout_end", e0 + 17, 7, 0, 2'b00, 1'b0);
    repeat (20) tick();

    step("m11", MODE, 7, 0, 2'b01, 0);
    tick();
    tick();
    e0 = cyc + 1;
    expect_at("incdec_to", e0 + 16, 7, 0, 2'b00, 1'b1);
    expect_at("incdec_to_end", e0 + 17, 7, 0, 2'b00, 1'b0);
    drive(4'b0110, 1);
    repeat (20) tick();

    step("m12", MODE, 7, 0, 2'b01, 0);
    step("m13", MODE, 7, 0, 2'b10, 0);
    for (int m = 1; m <= 10; m++)
      step("min_up2", INC, 7, m, 2'b10, 0);
    e0 = cyc + 1;
    expect_at("rep_edge", e0, 7, 11, 2'b10, 1'b0);
    expect_at("rep_delay", e0 + 8, 7, 12, 2'b10, 1'b0);
    expect_at("rep_rate1", e0 + 12, 7, 13, 2'b10, 1'b0);
    expect_at("rep_rate2", e0 + 16, 7, 14, 2'b10, 1'b0);
    expect_at("rep_to", e0 + 32, 7, 14, 2'b00, 1'b1);
    expect_at("rep_to_end", e0 + 33, 7, 14, 2'b00, 1'b0);
    drive(4'b0010, 20);
    repeat (20) tick();

    repeat (3) tick();
    n_chk++;
    if (q.size() == 0) n_pass++;
    else
      $display("FAIL pending: got %0d unseen events (next %s), want 0",
               q.size(), q[0].nm);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alarm_time_setter.md
Name: alarm_time_setter

Overview:
- Button-driven editor that produces the alarm time `a_hr`/`a_min` consumed by the alarm compare/display block.
- Does its own rising-edge detection on debounced button levels.
- Runs a 3-state edit FSM with hold-to-repeat, inactivity timeout and cancel-restore.
- Output registers feed the alarm comparator directly; the previous committed value is kept in a shadow copy for cancel.

Parameters:
- RST_HR, 6, alarm hour loaded at reset (0..23)
- RST_MIN, 0, alarm minute loaded at reset (0..59)
- REPEAT_DELAY, 50_000_000, clk cycles inc/dec must be held before auto-repeat starts
- REPEAT_RATE, 10_000_000, clk cycles between auto-repeat steps
- TIMEOUT, 500_000_000, idle clk cycles in an edit state before auto-commit

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- btn  in  4  debounced, synchronised button levels; [0]=mode, [1]=inc, [2]=dec, [3]=cancel
- a_hr  out  6  alarm hour, 0..23, registered
- a_min  out  6  alarm minute, 0..59, registered
- editing  out  1  high in SET_HR or SET_MIN
- field  out  2  00=none, 01=hour, 10=minute (display blink select)
- upd  out  1  one-cycle pulse when an edit is committed

Behaviour:
- Reset (async, rst=1):
  - a_hr=RST_HR, a_min=RST_MIN; shadow copies equal the same values.
  - State IDLE; editing=0, field=00, upd=0.
  - All counters and previous-button registers are 0.
- Edge detect: p[i] = btn[i] & ~btn_q[i], with btn_q registered every cycle. A press yields exactly one pulse, in the cycle after the level rises.
- Priority in the same cycle: cancel > mode > inc/dec. If inc and dec pulse together, no step is taken.
- FSM states: IDLE, SET_HR, SET_MIN.
  - IDLE:
    - mode -> SET_HR; shadow <= current a_hr/a_min.
    - inc/dec/cancel are ignored.
  - SET_HR:
    - inc: a_hr = (a_hr==23) ? 0 : a_hr+1.
    - dec: a_hr = (a_hr==0) ? 23 : a_hr-1.
    - mode -> SET_MIN.
  - SET_MIN:
    - inc/dec step a_min with wrap 59<->0.
    - mode -> IDLE, upd=1 for one cycle (commit).
  - Cancel in SET_HR or SET_MIN: a_hr/a_min <= shadow, -> IDLE, upd stays 0.
- Field stepping never carries: minute wrap does not change the hour.
- Auto-repeat:
  - hold_cnt counts while exactly one of btn[1]/btn[2] is high in an edit state.
  - It clears on release, on a state change, or when both are high.
  - The first step comes from the edge pulse.
  - When hold_cnt reaches REPEAT_DELAY-1, one step is taken and rep_cnt starts.
  - A further step is taken every REPEAT_RATE cycles while the button stays held.
- Timeout:
  - idle_cnt clears on any edge pulse or state change and counts in edit states only.
  - At TIMEOUT-1: commit exactly as mode does in SET_MIN (-> IDLE, upd=1), from either edit state.
- Outputs:
  - a_hr/a_min change live during edit, so the comparator sees the working value.
  - editing and field are decoded from the registered state. field is registered-equivalent and never glitches.
- Counter widths: $clog2 of the relevant parameter + 1. Counters saturate and do not wrap while held.
- Arithmetic range: a_hr is never >23 and a_min is never >59 under any button sequence.
- Reset mid-edit: immediate return to RST values and IDLE. The shadow is also reset, so the pre-edit alarm is lost.
- Mode held continuously: only one transition (edge-based).

Test Plan:
- Reset with RST_HR=6, RST_MIN=0 -> a_hr=6, a_min=0, editing=0, field=00, upd=0. Assert rst mid-count -> same values on the next sample.
- mode, inc x3 (separate presses), mode, dec x1, mode -> a_hr=9, a_min=59, field sequence 01->10->00, upd one pulse at final mode.
- Wrap checks:
  - a_hr=23, inc -> 0; then dec -> 23.
  - a_min=0, dec -> 59 with a_hr unchanged.
- Auto-repeat (REPEAT_DELAY=8, REPEAT_RATE=4): hold inc 20 cycles in SET_MIN from a_min=10 -> a_min=14 (edge +1, delay +1, two rate steps +2 = 4 steps), exact step cycles checked.
- Cancel: from a_hr=6/a_min=0, mode, inc x2, mode, inc x5, cancel -> a_hr=6, a_min=0, IDLE, upd never pulsed. Cancel+mode+inc in the same cycle -> cancel wins.
- Timeout (TIMEOUT=16): enter SET_HR, inc once, no further presses -> IDLE and upd pulse exactly 16 cycles after last edge, a_hr retains the incremented value. inc+dec simultaneous -> no step, idle_cnt cleared.
